shift_issue_ctrl: RTL and testbench
===================================

# shift_issue_ctrl

- Two-stage valid/ready front-end and back-end for the N-bit barrel shifter.
- Accepts shift commands (operand, amount, opcode) from the execute issue path and decodes the opcode into shifter control levels.
- Registers the operands that drive the shifter and captures the shifter's combinational result into an output register with status flags.
- Sits directly around the shifter: its `sh_*` outputs feed the shifter and `sh_out` is the shifter's result.

## Interface

Parameters:
- `N`, 8: operand width, power of two, ≥ 4.
- `B`, $clog2(N): shift-amount width.

Ports:
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: command valid.
- `in_ready` output 1: command accepted when `in_valid & in_ready` at a rising edge.
- `in_num` input N: operand.
- `in_amt` input B: shift amount.
- `in_op` input 3: 0 LSL, 1 LSR, 2 ASR, 3 ROL, 4 ROR, 5–7 illegal.
- `sh_num` output N: operand to shifter.
- `sh_amt` output B: amount to shifter.
- `sh_left` output 1: 1 = left direction.
- `sh_asr` output 1: arithmetic right.
- `sh_rotate` output 1: rotate mode.
- `sh_out` input N: shifter result, combinational from `sh_*`.
- `out_valid` output 1: result valid.
- `out_ready` input 1: result consumed when `out_valid & out_ready`.
- `out_data` output N: result.
- `out_err` output 1: illegal opcode.
- `out_zero`, `out_neg`, `out_carry` output 1 each: status flags.
- `op_count` output 16: count of completed (consumed) results.

## Operation

Stage A (operand register: `a_valid`, num, amt, op):
- Drives `sh_*` every cycle.
- Decode: LSL → left=1, asr=0, rot=0. LSR → 0/0/0. ASR → 0/1/0. ROL → 1/0/1. ROR → 0/0/1.
- Illegal op → all three 0 and `sh_amt` = 0.

Stage B (result register):
- Captures `out_data`, `out_err`, and flags from stage A.
- Illegal op: `out_data` = `in_num` unchanged, `out_err` = 1, flags computed on that data, carry = 0.

Advance rules:
- `b_adv = a_valid & (!out_valid | out_ready)`.
- `in_ready = !a_valid | b_adv` (combinational; full throughput of one command per cycle).
- Stage A loads on acceptance.
- Stage A clears when `b_adv` fires with no new acceptance in the same cycle.

Flags:
- zero = (result == 0).
- neg = result[N-1].
- carry, with amt = 0 → 0; otherwise:
  - LSL: num[N-amt].
  - LSR/ASR: num[amt-1].
  - ROL: result[0].
  - ROR: result[N-1].
- Amount arithmetic is modulo-free: amt < N by width, so no wrap cases beyond rotate.

`op_count`: increments on each `out_valid & out_ready`, saturates at 16'hFFFF.

Reset (`rst_n` low, asynchronous):
- `a_valid` = 0, `out_valid` = 0.
- `out_data`, `out_err`, flags, `op_count` = 0.
- Stage A operand registers = 0, so `sh_*` = 0.
- Reset mid-operation discards both stages without producing output.

## Timing

- Latency: command accepted at edge T appears on `out_*` with `out_valid` = 1 after edge T+1.
- Back-to-back: with `out_ready` held high, one result per cycle, no bubbles.
- Stall: with `out_ready` low and `out_valid` = 1:
  - Stage A holds; `in_ready` drops after one further acceptance.
  - `out_*` holds stable until consumed.
- Simultaneous accept and advance in one cycle: stage A reloads while stage B captures the old stage A contents.
- Outputs are registered, except `in_ready` and `sh_*` (`sh_*` are register-driven decode).

## Configuration

- `SHIFT_CTRL_FLAGS_EN` defined: zero/neg/carry computed and registered as above.
- Not defined: the carry and flag logic is not instantiated and `out_zero`, `out_neg`, `out_carry` are tied to 0.
- `out_err`, `out_data`, and `op_count` are unaffected either way.

## Test plan

- N=8, LSL `in_num`=8'hB5, amt=3, `out_ready`=1 → after 2 edges `out_data`=8'hA8, carry=1, neg=1, zero=0, `op_count`=1.
- ASR 8'h90, amt=4 → 8'hF9, carry=0, neg=1. ROR 8'h01, amt=1 → 8'h80, carry=1.
- Illegal op 6, num 8'h3C → `out_data`=8'h3C, `out_err`=1, `sh_left`/`sh_asr`/`sh_rotate`=0.
- Backpressure:
  - Issue 3 commands back-to-back with `out_ready`=0 → `in_ready` falls after the 2nd acceptance and the first result holds stable.
  - Raise `out_ready` → results emerge in order, one per cycle, `op_count`=3.
- Assert `rst_n` low mid-stream with both stages full → all outputs 0 immediately (asynchronous), no result emitted, `op_count`=0.
- Build without `SHIFT_CTRL_FLAGS_EN`, LSL 8'h80 amt=1 → `out_data`=8'h00, `out_zero`=`out_carry`=`out_neg`=0.

Source files
------------

// File: rtl/shift_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// shift_issue_ctrl_if
// Command and result handshake bundle for shift_issue_ctrl.
//   in_valid/in_ready  : command handshake from the execute issue path
//   in_num/in_amt/in_op: operand, shift amount, opcode (0 LSL, 1 LSR, 2 ASR,
//                        3 ROL, 4 ROR, 5-7 illegal)
//   out_valid/out_ready: result handshake toward the consumer
//   out_data/out_err   : result and illegal-opcode marker
//   out_zero/out_neg/out_carry: status flags
// Modports: master = issuer/consumer side, slave = shift_issue_ctrl.
// ---------------------------------------------------------------------------
interface shift_issue_ctrl_if #(
    parameter int N = 8,
    parameter int B = $clog2(N)
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_num;
    logic [B-1:0] in_amt;
    logic [2:0]   in_op;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic         out_err;
    logic         out_zero;
    logic         out_neg;
    logic         out_carry;

    modport master (
        output in_valid, in_num, in_amt, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_err, out_zero, out_neg, out_carry
    );

    modport slave (
        input  in_valid, in_num, in_amt, in_op, out_ready,
        output in_ready, out_valid, out_data, out_err, out_zero, out_neg, out_carry
    );
endinterface

// File: rtl/shift_issue_ctrl.sv
// ---------------------------------------------------------------------------
// shift_issue_ctrl
// Two-stage valid/ready wrapper around an external combinational N-bit barrel
// shifter. Stage A registers the command and drives the shifter controls;
// stage B captures the shifter result plus status flags.
//
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   bus          : shift_issue_ctrl_if.slave (command in, result out)
//   sh_num/sh_amt/sh_left/sh_asr/sh_rotate : controls to the shifter
//   sh_out       : shifter result (combinational from sh_*)
//   op_count     : saturating count of consumed results
//
// Configuration macro: SHIFT_CTRL_FLAGS_EN
//   defined     -> zero/neg/carry computed and registered
//   not defined -> flag logic absent, out_zero/out_neg/out_carry tied to 0
// ---------------------------------------------------------------------------
module shift_issue_ctrl #(
    parameter int N = 8,
    parameter int B = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    shift_issue_ctrl_if.slave bus,
    output logic [N-1:0]      sh_num,
    output logic [B-1:0]      sh_amt,
    output logic              sh_left,
    output logic              sh_asr,
    output logic              sh_rotate,
    input  logic [N-1:0]      sh_out,
    output logic [15:0]       op_count
);
    localparam logic [2:0] OP_LSL = 3'd0;
    localparam logic [2:0] OP_LSR = 3'd1;
    localparam logic [2:0] OP_ASR = 3'd2;
    localparam logic [2:0] OP_ROL = 3'd3;
    localparam logic [2:0] OP_ROR = 3'd4;

    // Stage A
    logic         a_valid_r;
    logic [N-1:0] a_num_r;
    logic [B-1:0] a_amt_r;
    logic [2:0]   a_op_r;
    // Stage B
    logic         b_valid_r;
    logic [N-1:0] b_data_r;
    logic         b_err_r;
    logic [15:0]  op_count_r;

    logic         b_adv_s;
    logic         accept_s;
    logic         consume_s;
    logic         a_illegal_s;
    logic         dec_left_s;
    logic         dec_asr_s;
    logic         dec_rot_s;
    logic [N-1:0] res_data_s;

    // Handshake: stage B takes stage A when empty or being drained this cycle.
    assign b_adv_s   = a_valid_r & (~b_valid_r | bus.out_ready);
    assign accept_s  = bus.in_valid & bus.in_ready;
    assign consume_s = b_valid_r & bus.out_ready;
    assign bus.in_ready = ~a_valid_r | b_adv_s;

    // Opcode decode into shifter control levels.
    always_comb begin
        dec_left_s  = 1'b0;
        dec_asr_s   = 1'b0;
        dec_rot_s   = 1'b0;
        a_illegal_s = 1'b0;
        case (a_op_r)
            OP_LSL: begin
                dec_left_s = 1'b1;
            end
            OP_LSR: begin
                dec_left_s = 1'b0;
            end
            OP_ASR: begin
                dec_asr_s = 1'b1;
            end
            OP_ROL: begin
                dec_left_s = 1'b1;
                dec_rot_s  = 1'b1;
            end
            OP_ROR: begin
                dec_rot_s = 1'b1;
            end
            default: begin
                a_illegal_s = 1'b1;
            end
        endcase
    end

    // Direction/mode levels are qualified by a_valid_r so that the reset
    // contents (op 0 = LSL) do not present a left shift while idle.
    assign sh_num    = a_num_r;
    assign sh_amt    = a_illegal_s ? {B{1'b0}} : a_amt_r;
    assign sh_left   = a_valid_r & dec_left_s;
    assign sh_asr    = a_valid_r & dec_asr_s;
    assign sh_rotate = a_valid_r & dec_rot_s;

    // Illegal opcodes pass the operand through untouched.
    assign res_data_s = a_illegal_s ? a_num_r : sh_out;

    // Stage A: load on acceptance, empty when drained without a refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid_r <= 1'b0;
            a_num_r   <= {N{1'b0}};
            a_amt_r   <= {B{1'b0}};
            a_op_r    <= 3'd0;
        end else if (accept_s) begin
            a_valid_r <= 1'b1;
            a_num_r   <= bus.in_num;
            a_amt_r   <= bus.in_amt;
            a_op_r    <= bus.in_op;
        end else if (b_adv_s) begin
            a_valid_r <= 1'b0;
        end
    end

    // Stage B: capture result on advance, drop valid once consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_valid_r <= 1'b0;
            b_data_r  <= {N{1'b0}};
            b_err_r   <= 1'b0;
        end else if (b_adv_s) begin
            b_valid_r <= 1'b1;
            b_data_r  <= res_data_s;
            b_err_r   <= a_illegal_s;
        end else if (consume_s) begin
            b_valid_r <= 1'b0;
        end
    end

    // Saturating count of consumed results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_r <= 16'h0000;
        end else if (consume_s && (op_count_r != 16'hFFFF)) begin
            op_count_r <= op_count_r + 16'h0001;
        end
    end

    assign bus.out_valid = b_valid_r;
    assign bus.out_data  = b_data_r;
    assign bus.out_err   = b_err_r;
    assign op_count      = op_count_r;

`ifdef SHIFT_CTRL_FLAGS_EN
    logic res_zero_s;
    logic res_neg_s;
    logic res_carry_s;
    logic zero_r;
    logic neg_r;
    logic carry_r;

    // Last bit shifted out (or wrapped, for rotates); zero amount yields 0.
    // For LSL the index N-amt is taken modulo 2^B, valid because amt >= 1.
    function automatic logic carry_calc(
        input logic [N-1:0] num,
        input logic [B-1:0] amt,
        input logic [2:0]   op,
        input logic [N-1:0] res
    );
        logic [B-1:0] lsl_idx;
        logic [B-1:0] rsh_idx;
        logic         c;
        lsl_idx = B'(N - int'(amt));
        rsh_idx = B'(int'(amt) - 32'sd1);
        if (amt == {B{1'b0}}) begin
            c = 1'b0;
        end else begin
            case (op)
                OP_LSL:  c = num[lsl_idx];
                OP_LSR:  c = num[rsh_idx];
                OP_ASR:  c = num[rsh_idx];
                OP_ROL:  c = res[0];
                OP_ROR:  c = res[N-1];
                default: c = 1'b0;
            endcase
        end
        return c;
    endfunction

    // Flag evaluation on the stage-A result.
    always_comb begin
        res_zero_s  = (res_data_s == {N{1'b0}});
        res_neg_s   = res_data_s[N-1];
        res_carry_s = carry_calc(a_num_r, a_amt_r, a_op_r, res_data_s);
    end

    // Flag registers, captured alongside the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_r  <= 1'b0;
            neg_r   <= 1'b0;
            carry_r <= 1'b0;
        end else if (b_adv_s) begin
            zero_r  <= res_zero_s;
            neg_r   <= res_neg_s;
            carry_r <= res_carry_s;
        end
    end

    assign bus.out_zero  = zero_r;
    assign bus.out_neg   = neg_r;
    assign bus.out_carry = carry_r;
`else
    assign bus.out_zero  = 1'b0;
    assign bus.out_neg   = 1'b0;
    assign bus.out_carry = 1'b0;
`endif

endmodule

// File: tb/tb_shift_issue_ctrl.sv
module tb_shift_issue_ctrl;
    localparam int N = 8;
    localparam int B = 3;

    typedef struct packed {
        logic [7:0] data;
        logic       err;
        logic       zero;
        logic       neg;
        logic       carry;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [7:0]  sh_num;
    logic [2:0]  sh_amt;
    logic        sh_left;
    logic        sh_asr;
    logic        sh_rotate;
    logic [7:0]  sh_out;
    logic [15:0] op_count;

    int   total;
    int   bad;
    int   stall_cycles;
    exp_t exp_q[$];
    exp_t mon_e;

    shift_issue_ctrl_if #(.N(N), .B(B)) bus ();

    shift_issue_ctrl #(.N(N), .B(B)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .sh_num    (sh_num),
        .sh_amt    (sh_amt),
        .sh_left   (sh_left),
        .sh_asr    (sh_asr),
        .sh_rotate (sh_rotate),
        .sh_out    (sh_out),
        .op_count  (op_count)
    );

    // Combinational barrel shifter the controller sits around.
    logic [15:0] rot_tmp;
    always_comb begin
        rot_tmp = 16'h0000;
        if (sh_rotate) begin
            if (sh_left) begin
                rot_tmp = {sh_num, sh_num} << sh_amt;
                sh_out  = rot_tmp[15:8];
            end else begin
                rot_tmp = {sh_num, sh_num} >> sh_amt;
                sh_out  = rot_tmp[7:0];
            end
        end else if (sh_left) begin
            sh_out = sh_num << sh_amt;
        end else if (sh_asr) begin
            sh_out = $signed(sh_num) >>> sh_amt;
        end else begin
            sh_out = sh_num >> sh_amt;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] d, input logic err,
                                input logic z, input logic n, input logic c);
        exp_t e;
        e.data = d;
        e.err  = err;
`ifdef SHIFT_CTRL_FLAGS_EN
        e.zero  = z;
        e.neg   = n;
        e.carry = c;
`else
        e.zero  = 1'b0;
        e.neg   = 1'b0;
        e.carry = 1'b0;
`endif
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] num, input logic [2:0] amt,
                         input logic [2:0] op, input exp_t e);
        int n;
        bus.in_valid = 1'b1;
        bus.in_num   = num;
        bus.in_amt   = amt;
        bus.in_op    = op;
        #1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        stall_cycles += n;
        if (!bus.in_ready) begin
            total++;
            bad++;
            $display("FAIL issue_timeout: got in_ready=0 expected 1 within 50 cycles");
        end else begin
            exp_q.push_back(e);
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        tick();
    endtask

    // Scoreboard monitor: compares each result as it is handed over.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got data %0h expected no result", bus.out_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("result", {bus.out_data, bus.out_err, bus.out_zero, bus.out_neg, bus.out_carry}, mon_e);
            end
        end
    end

    initial begin
        total = 0;
        bad = 0;
        stall_cycles = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_num = 8'h00;
        bus.in_amt = 3'd0;
        bus.in_op = 3'd0;
        bus.out_ready = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_flags", {bus.out_err, bus.out_zero, bus.out_neg, bus.out_carry}, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_sh", {sh_num, sh_amt, sh_left, sh_asr, sh_rotate}, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        rst_n = 1'b1;
        tick();

        // Single LSL with latency check
        bus.out_ready = 1'b1;
        issue(8'hB5, 3'd3, 3'd0, mk(8'hA8, 1'b0, 1'b0, 1'b1, 1'b1));
        chk("lsl_sh_ctrl", {sh_num, sh_amt, sh_left, sh_asr, sh_rotate}, {8'hB5, 3'd3, 3'b100});
        chk("lat_not_early", bus.out_valid, 0);
        tick();
        chk("lat_valid", bus.out_valid, 1);
        chk("lat_data", bus.out_data, 8'hA8);
        tick();
        chk("count_1", op_count, 1);

        // Back-to-back stream, no stalls expected
        stall_cycles = 0;
        issue(8'h90, 3'd4, 3'd2, mk(8'hF9, 1'b0, 1'b0, 1'b1, 1'b0));
        issue(8'h01, 3'd1, 3'd4, mk(8'h80, 1'b0, 1'b0, 1'b1, 1'b1));
        issue(8'h81, 3'd1, 3'd3, mk(8'h03, 1'b0, 1'b0, 1'b0, 1'b1));
        issue(8'h01, 3'd1, 3'd1, mk(8'h00, 1'b0, 1'b1, 1'b0, 1'b1));
        issue(8'h80, 3'd0, 3'd0, mk(8'h80, 1'b0, 1'b0, 1'b1, 1'b0));
        issue(8'hB5, 3'd7, 3'd1, mk(8'h01, 1'b0, 1'b0, 1'b0, 1'b0));
        issue(8'h3C, 3'd5, 3'd6, mk(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0));
        chk("illegal_sh_ctrl", {sh_amt, sh_left, sh_asr, sh_rotate}, 0);
        chk("b2b_stalls", stall_cycles, 0);
        drain();
        chk("count_8", op_count, 8);

        // Backpressure
        do_reset();
        bus.out_ready = 1'b0;
        issue(8'h0F, 3'd4, 3'd0, mk(8'hF0, 1'b0, 1'b0, 1'b1, 1'b0));
        issue(8'hF0, 3'd4, 3'd1, mk(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0));
        chk("bp_in_ready_low", bus.in_ready, 0);
        chk("bp_out_valid", bus.out_valid, 1);
        bus.in_valid = 1'b1;
        bus.in_num = 8'h03;
        bus.in_amt = 3'd1;
        bus.in_op = 3'd4;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_data", bus.out_data, 8'hF0);
            chk("bp_hold_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_ready_back", bus.in_ready, 1);
        exp_q.push_back(mk(8'h81, 1'b0, 1'b0, 1'b1, 1'b1));
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        chk("bp_drained", exp_q.size(), 0);
        chk("bp_count_3", op_count, 3);

        // Asynchronous reset with both stages full
        bus.out_ready = 1'b0;
        issue(8'h90, 3'd4, 3'd2, mk(8'hF9, 1'b0, 1'b0, 1'b1, 1'b0));
        issue(8'h81, 3'd1, 3'd3, mk(8'h03, 1'b0, 1'b0, 1'b0, 1'b1));
        chk("pre_rst_full", {bus.out_valid, bus.in_ready}, 2'b10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_out_data", bus.out_data, 0);
        chk("arst_flags", {bus.out_err, bus.out_zero, bus.out_neg, bus.out_carry}, 0);
        chk("arst_op_count", op_count, 0);
        chk("arst_sh", {sh_num, sh_amt, sh_left, sh_asr, sh_rotate}, 0);
        exp_q.delete();
        bus.out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        chk("post_rst_no_out", bus.out_valid, 0);
        chk("post_rst_count", op_count, 0);

        // LSL 80 by 1: flags present only when the feature is built in
        issue(8'h80, 3'd1, 3'd0, mk(8'h00, 1'b0, 1'b1, 1'b0, 1'b1));
        drain();
        chk("final_count", op_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
